// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and its datapath/memory.
interface multicycle_controller_if;
   logic [5:0] OPCode;
   logic [5:0] FCode;
   logic       Zero;
   logic       mem_ready;
   logic [4:0] AluCtr;
   logic       AluMUX1;
   logic       AluMUX2;
   logic       RegWrite;
   logic       selectReg;
   logic       MemtoReg;
   logic       MemRead;
   logic       MemWrite;
   logic       IorD;
   logic       IRWrite;
   logic       PCWrite;
   logic [1:0] PCSrc;

   modport master (
      input  OPCode, FCode, Zero, mem_ready,
      output AluCtr, AluMUX1, AluMUX2, RegWrite, selectReg, MemtoReg,
             MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc
   );

   modport slave (
      output OPCode, FCode, Zero, mem_ready,
      input  AluCtr, AluMUX1, AluMUX2, RegWrite, selectReg, MemtoReg,
             MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM sequencing a shared-memory datapath.
//  state  | meaning
//  FETCH  | read instruction at PC, wait for mem_ready, load IR and PC+4
//  DECODE | latch opcode/funct, J completes here, unsupported -> TRAP
//  EXEC   | ALU operation, branches resolve and complete here
//  MEM    | LW/SW data access at ALU address, wait for mem_ready
//  ALUWB  | write ALU result to rd/rt
//  MEMWB  | write loaded data to rt
//  TRAP   | unsupported instruction, held until reset
module multicycle_controller #(
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   multicycle_controller_if.master bus,
   output logic                 retire,
   output logic [CNT_W-1:0]     instr_count,
   output logic                 illegal,
   output logic [2:0]           state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_ALUWB  = 3'd4,
      S_MEMWB  = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_t           state_q, state_d;
   logic [5:0]       op_q, op_d, fn_q, fn_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             illegal_q, illegal_d;

   // {supported, alu_ctr}; J is handled outside the table
   function automatic logic [5:0] decode_op(input logic [5:0] op, input logic [5:0] fn);
      logic [5:0] r;
      r = 6'd0;
      case (op)
         OP_RTYPE: begin
            case (fn)
               6'b100000: r = {1'b1, 5'd0};
               6'b100010: r = {1'b1, 5'd1};
               6'b100100: r = {1'b1, 5'd2};
               6'b100101: r = {1'b1, 5'd3};
               6'b000011: r = {1'b1, 5'd4};
               6'b000010: r = {1'b1, 5'd5};
               6'b000000: r = {1'b1, 5'd6};
               6'b000100: r = {1'b1, 5'd7};
               6'b101010: r = {1'b1, 5'd8};
               default:   r = 6'd0;
            endcase
         end
         6'b001000: r = {1'b1, 5'd9};
         6'b001001: r = {1'b1, 5'd10};
         6'b001100: r = {1'b1, 5'd11};
         6'b001101: r = {1'b1, 5'd12};
         6'b001111: r = {1'b1, 5'd13};
         6'b001011: r = {1'b1, 5'd14};
         6'b001010: r = {1'b1, 5'd15};
         OP_BEQ:    r = {1'b1, 5'd16};
         OP_BNE:    r = {1'b1, 5'd17};
         OP_LW:     r = {1'b1, 5'd18};
         OP_SW:     r = {1'b1, 5'd19};
         default:   r = 6'd0;
      endcase
      return r;
   endfunction

   logic [5:0] dec_live, dec_q;
   logic       is_branch_q, is_mem_q, is_shift_q, uses_imm_q;

   assign dec_live    = decode_op(bus.OPCode, bus.FCode);
   assign dec_q       = decode_op(op_q, fn_q);
   assign is_branch_q = (op_q == OP_BEQ) || (op_q == OP_BNE);
   assign is_mem_q    = (op_q == OP_LW) || (op_q == OP_SW);
   assign is_shift_q  = (op_q == OP_RTYPE) &&
                        ((fn_q == 6'b000011) || (fn_q == 6'b000010) || (fn_q == 6'b000000));
   assign uses_imm_q  = (op_q != OP_RTYPE) && !is_branch_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         op_q      <= 6'd0;
         fn_q      <= 6'd0;
         count_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         fn_q      <= fn_d;
         count_q   <= count_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      fn_d    = fn_q;
      case (state_q)
         S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            op_d = bus.OPCode;
            fn_d = bus.FCode;
            if (bus.OPCode == OP_J)  state_d = S_FETCH;
            else if (dec_live[5])    state_d = S_EXEC;
            else                     state_d = S_TRAP;
         end
         S_EXEC: begin
            if (is_branch_q)    state_d = S_FETCH;
            else if (is_mem_q)  state_d = S_MEM;
            else                state_d = S_ALUWB;
         end
         S_MEM:    if (bus.mem_ready) state_d = (op_q == OP_LW) ? S_MEMWB : S_FETCH;
         S_ALUWB,
         S_MEMWB:  state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_FETCH;
      endcase
      count_d   = count_q + CNT_W'(retire);
      illegal_d = illegal_q | (state_d == S_TRAP);
   end

   // Reset masks every strobe so a pending memory access is dropped at once
   always_comb begin
      bus.AluCtr    = 5'd0;
      bus.AluMUX1   = 1'b0;
      bus.AluMUX2   = 1'b0;
      bus.RegWrite  = 1'b0;
      bus.selectReg = 1'b0;
      bus.MemtoReg  = 1'b0;
      bus.MemRead   = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.IorD      = 1'b0;
      bus.IRWrite   = 1'b0;
      bus.PCWrite   = 1'b0;
      bus.PCSrc     = 2'b00;
      retire        = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               bus.MemRead = 1'b1;
               if (bus.mem_ready) begin
                  bus.IRWrite = 1'b1;
                  bus.PCWrite = 1'b1;
               end
            end
            S_DECODE: begin
               if (bus.OPCode == OP_J) begin
                  bus.PCWrite = 1'b1;
                  bus.PCSrc   = 2'b10;
                  retire      = 1'b1;
               end
            end
            S_EXEC: begin
               bus.AluCtr  = dec_q[4:0];
               bus.AluMUX1 = is_shift_q;
               bus.AluMUX2 = uses_imm_q;
               if (is_branch_q) begin
                  bus.PCWrite = (op_q == OP_BEQ) ? bus.Zero : !bus.Zero;
                  bus.PCSrc   = 2'b01;
                  retire      = 1'b1;
               end
            end
            S_MEM: begin
               bus.IorD     = 1'b1;
               bus.AluCtr   = dec_q[4:0];
               bus.AluMUX2  = uses_imm_q;
               bus.MemRead  = (op_q == OP_LW);
               bus.MemWrite = (op_q == OP_SW);
               retire       = bus.mem_ready && (op_q == OP_SW);
            end
            S_ALUWB: begin
               bus.RegWrite  = 1'b1;
               bus.selectReg = (op_q == OP_RTYPE);
               retire        = 1'b1;
            end
            S_MEMWB: begin
               bus.RegWrite = 1'b1;
               bus.MemtoReg = 1'b1;
               retire       = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign instr_count = count_q;
   assign illegal     = illegal_q;
   assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-scenario tasks plus a retire scoreboard.
module tb_multicycle_controller;

   localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                          S_ALUWB = 3'd4, S_MEMWB = 3'd5, S_TRAP = 3'd6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [5:0] op_r = 6'd0, fn_r = 6'd0;
   logic zero_r = 1'b0, mr_r = 1'b0;

   multicycle_controller_if bus16 ();
   multicycle_controller_if bus4 ();

   assign bus16.OPCode = op_r;  assign bus16.FCode = fn_r;
   assign bus16.Zero = zero_r;  assign bus16.mem_ready = mr_r;
   assign bus4.OPCode = op_r;   assign bus4.FCode = fn_r;
   assign bus4.Zero = zero_r;   assign bus4.mem_ready = mr_r;

   logic        retire16, illegal16, retire4, illegal4;
   logic [15:0] cnt16;
   logic [3:0]  cnt4;
   logic [2:0]  st16, st4;

   multicycle_controller #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .bus(bus16.master),
      .retire(retire16), .instr_count(cnt16), .illegal(illegal16), .state(st16)
   );

   multicycle_controller #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.master),
      .retire(retire4), .instr_count(cnt4), .illegal(illegal4), .state(st4)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] AluCtr;
      logic       AluMUX1, AluMUX2, RegWrite, selectReg, MemtoReg;
      logic       MemRead, MemWrite, IorD, IRWrite, PCWrite;
      logic [1:0] PCSrc;
      logic       retire, illegal;
   } snap_t;

   logic [2:0] tr_st [64];
   snap_t      tr_sn [64];
   int         tr_len;
   int         checks = 0;
   int         errors = 0;
   int         model_cnt = 0;
   int         exp_q [$];

   function automatic snap_t take();
      snap_t s;
      s.AluCtr = bus16.AluCtr;     s.AluMUX1 = bus16.AluMUX1;   s.AluMUX2 = bus16.AluMUX2;
      s.RegWrite = bus16.RegWrite; s.selectReg = bus16.selectReg;
      s.MemtoReg = bus16.MemtoReg; s.MemRead = bus16.MemRead;   s.MemWrite = bus16.MemWrite;
      s.IorD = bus16.IorD;         s.IRWrite = bus16.IRWrite;   s.PCWrite = bus16.PCWrite;
      s.PCSrc = bus16.PCSrc;       s.retire = retire16;         s.illegal = illegal16;
      return s;
   endfunction

   function automatic logic any_strobe();
      return bus16.RegWrite | bus16.MemRead | bus16.MemWrite | bus16.IRWrite |
             bus16.PCWrite | retire16 | bus4.MemRead | bus4.MemWrite | retire4;
   endfunction

   // Called at a negedge; returns at a negedge with reset released
   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) begin
         #1;
         checks++;
         if (any_strobe() !== 1'b0) begin
            errors++;
            $display("FAIL reset_strobes: got strobe=%b, want 0", any_strobe());
         end
         @(negedge clk);
      end
      reset = 1'b0;
      model_cnt = 0;
      exp_q.delete();
   endtask

   // Walks one instruction, recording one snapshot per cycle, until retire or TRAP
   task automatic exec_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero,
                             input int fwait, input int mwait, input bit exp_retire);
      int fcnt, mcnt, exp;
      bit done;
      fcnt = 0; mcnt = 0; done = 0;
      op_r = op; fn_r = fn; zero_r = zero; tr_len = 0;
      if (exp_retire) exp_q.push_back((model_cnt + 1) & 32'hFFFF);
      for (int i = 0; i < 40 && !done; i++) begin
         if (st16 == S_FETCH)    begin mr_r = (fcnt >= fwait); fcnt++; end
         else if (st16 == S_MEM) begin mr_r = (mcnt >= mwait); mcnt++; end
         else                    mr_r = 1'b1;
         #1;
         tr_st[tr_len] = st16;
         tr_sn[tr_len] = take();
         tr_len++;
         if (retire16 === 1'b1 || st16 == S_TRAP) done = 1;
         else @(negedge clk);
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL instr_timeout: op=%b no retire/trap within 40 cycles, want completion", op);
      end else if (retire16 === 1'b1) begin
         @(posedge clk);
         #1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: retire seen, want queued expectation");
         end else begin
            exp = exp_q.pop_front();
            if (cnt16 !== exp[15:0]) begin
               errors++;
               $display("FAIL instr_count: got %0d, want %0d", cnt16, exp[15:0]);
            end
            model_cnt = exp;
         end
      end
      mr_r = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      op_r = 6'b000000; fn_r = 6'b100000; mr_r = 1'b1;
      do_reset(3);
      exec_instr(6'b000000, 6'b100000, 1'b0, 0, 0, 1);
      checks++;
      if (tr_len !== 4 || {tr_st[0], tr_st[1], tr_st[2], tr_st[3]} !== {S_FETCH, S_DECODE, S_EXEC, S_ALUWB}) begin
         errors++;
         $display("FAIL add_sequence: got len=%0d states=%0d,%0d,%0d,%0d, want 4 states 0,1,2,4",
                  tr_len, tr_st[0], tr_st[1], tr_st[2], tr_st[3]);
      end
      checks++;
      if (tr_sn[3].RegWrite !== 1'b1 || tr_sn[3].selectReg !== 1'b1 || tr_sn[3].MemtoReg !== 1'b0) begin
         errors++;
         $display("FAIL add_aluwb: got RegWrite=%b selectReg=%b MemtoReg=%b, want 1 1 0",
                  tr_sn[3].RegWrite, tr_sn[3].selectReg, tr_sn[3].MemtoReg);
      end
      checks++;
      if (tr_sn[2].AluCtr !== 5'd0) begin
         errors++;
         $display("FAIL add_aluctr: got %b, want 00000", tr_sn[2].AluCtr);
      end
      checks++;
      if (tr_sn[0].IRWrite !== 1'b1 || tr_sn[0].PCWrite !== 1'b1 || tr_sn[0].MemRead !== 1'b1 ||
          tr_sn[0].IorD !== 1'b0 || tr_sn[0].PCSrc !== 2'b00) begin
         errors++;
         $display("FAIL fetch_strobes: got IRWrite=%b PCWrite=%b MemRead=%b IorD=%b PCSrc=%b, want 1 1 1 0 00",
                  tr_sn[0].IRWrite, tr_sn[0].PCWrite, tr_sn[0].MemRead, tr_sn[0].IorD, tr_sn[0].PCSrc);
      end
   endtask

   task automatic test_lw_wait();
      int nf, nm, bad;
      nf = 0; nm = 0; bad = 0;
      exec_instr(6'b100011, 6'b000000, 1'b0, 3, 3, 1);
      for (int i = 0; i < tr_len; i++) begin
         if (tr_st[i] == S_FETCH) begin
            nf++;
            if (tr_sn[i].MemRead !== 1'b1) bad++;
         end
         if (tr_st[i] == S_MEM) begin
            nm++;
            if (tr_sn[i].MemRead !== 1'b1 || tr_sn[i].IorD !== 1'b1 || tr_sn[i].AluCtr !== 5'd18) bad++;
         end
      end
      checks++;
      if (nf !== 4 || nm !== 4 || bad !== 0) begin
         errors++;
         $display("FAIL lw_wait: got fetch=%0d mem=%0d bad=%0d, want 4 4 0", nf, nm, bad);
      end
      checks++;
      if (tr_len !== 11 || tr_st[10] !== S_MEMWB || tr_sn[10].RegWrite !== 1'b1 ||
          tr_sn[10].MemtoReg !== 1'b1 || tr_sn[10].selectReg !== 1'b0) begin
         errors++;
         $display("FAIL lw_memwb: got len=%0d st=%0d RegWrite=%b MemtoReg=%b selectReg=%b, want 11 5 1 1 0",
                  tr_len, tr_st[10], tr_sn[10].RegWrite, tr_sn[10].MemtoReg, tr_sn[10].selectReg);
      end
   endtask

   task automatic test_beq();
      for (int z = 1; z >= 0; z--) begin
         exec_instr(6'b000100, 6'b000000, z[0], 0, 0, 1);
         checks++;
         if (tr_len !== 3 || tr_st[2] !== S_EXEC || tr_sn[2].PCWrite !== z[0] ||
             tr_sn[2].PCSrc !== 2'b01 || tr_sn[2].AluCtr !== 5'b10000 || tr_sn[2].retire !== 1'b1) begin
            errors++;
            $display("FAIL beq_zero%0d: got len=%0d PCWrite=%b PCSrc=%b AluCtr=%b retire=%b, want 3 %0d 01 10000 1",
                     z, tr_len, tr_sn[2].PCWrite, tr_sn[2].PCSrc, tr_sn[2].AluCtr, tr_sn[2].retire, z);
         end
      end
   endtask

   task automatic test_shift();
      exec_instr(6'b000000, 6'b000000, 1'b0, 0, 0, 1);
      checks++;
      if (tr_sn[2].AluMUX1 !== 1'b1 || tr_sn[2].AluCtr !== 5'b00110) begin
         errors++;
         $display("FAIL sll: got AluMUX1=%b AluCtr=%b, want 1 00110", tr_sn[2].AluMUX1, tr_sn[2].AluCtr);
      end
      exec_instr(6'b000000, 6'b000100, 1'b0, 0, 0, 1);
      checks++;
      if (tr_sn[2].AluMUX1 !== 1'b0 || tr_sn[2].AluCtr !== 5'b00111) begin
         errors++;
         $display("FAIL sllv: got AluMUX1=%b AluCtr=%b, want 0 00111", tr_sn[2].AluMUX1, tr_sn[2].AluCtr);
      end
   endtask

   task automatic test_itype();
      exec_instr(6'b001101, 6'b111111, 1'b0, 0, 0, 1);
      checks++;
      if (tr_len !== 4 || tr_sn[2].AluCtr !== 5'd12 || tr_sn[2].AluMUX2 !== 1'b1 ||
          tr_sn[3].selectReg !== 1'b0 || tr_sn[3].RegWrite !== 1'b1) begin
         errors++;
         $display("FAIL ori: got len=%0d AluCtr=%0d AluMUX2=%b selectReg=%b RegWrite=%b, want 4 12 1 0 1",
                  tr_len, tr_sn[2].AluCtr, tr_sn[2].AluMUX2, tr_sn[3].selectReg, tr_sn[3].RegWrite);
      end
      exec_instr(6'b101011, 6'b000000, 1'b0, 0, 0, 1);
      checks++;
      if (tr_len !== 4 || tr_st[3] !== S_MEM || tr_sn[3].MemWrite !== 1'b1 ||
          tr_sn[3].MemRead !== 1'b0 || tr_sn[3].retire !== 1'b1) begin
         errors++;
         $display("FAIL sw: got len=%0d st=%0d MemWrite=%b MemRead=%b retire=%b, want 4 3 1 0 1",
                  tr_len, tr_st[3], tr_sn[3].MemWrite, tr_sn[3].MemRead, tr_sn[3].retire);
      end
   endtask

   task automatic test_trap();
      int bad;
      bad = 0;
      exec_instr(6'b111111, 6'b000000, 1'b0, 0, 0, 0);
      checks++;
      if (tr_st[tr_len-1] !== S_TRAP || tr_sn[tr_len-1].illegal !== 1'b1 || tr_len !== 3) begin
         errors++;
         $display("FAIL trap_entry: got st=%0d illegal=%b len=%0d, want 6 1 3",
                  tr_st[tr_len-1], tr_sn[tr_len-1].illegal, tr_len);
      end
      mr_r = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (illegal16 !== 1'b1 || any_strobe() !== 1'b0 || st16 !== S_TRAP) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL trap_hold: got %0d bad cycles, want 0", bad);
      end
      mr_r = 1'b0;
      do_reset(1);
      #1;
      checks++;
      if (illegal16 !== 1'b0 || st16 !== S_FETCH || cnt16 !== 16'd0) begin
         errors++;
         $display("FAIL trap_clear: got illegal=%b state=%0d count=%0d, want 0 0 0", illegal16, st16, cnt16);
      end
      @(negedge clk);
   endtask

   task automatic test_sw_reset();
      op_r = 6'b101011; fn_r = 6'b000000;
      for (int i = 0; i < 10 && st16 != S_MEM; i++) begin
         mr_r = 1'b1;
         @(negedge clk);
      end
      mr_r = 1'b0;
      #1;
      checks++;
      if (st16 !== S_MEM || bus16.MemWrite !== 1'b1) begin
         errors++;
         $display("FAIL sw_wait: got state=%0d MemWrite=%b, want 3 1", st16, bus16.MemWrite);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (bus16.MemWrite !== 1'b0 || retire16 !== 1'b0) begin
         errors++;
         $display("FAIL sw_reset_strobe: got MemWrite=%b retire=%b, want 0 0", bus16.MemWrite, retire16);
      end
      @(posedge clk);
      #1;
      checks++;
      if (st16 !== S_FETCH || cnt16 !== 16'd0) begin
         errors++;
         $display("FAIL sw_reset_state: got state=%0d count=%0d, want 0 0", st16, cnt16);
      end
      @(negedge clk);
      reset = 1'b0;
      model_cnt = 0;
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      do_reset(1);
      for (int i = 0; i < 16; i++) begin
         exec_instr(6'b000010, 6'b000000, 1'b0, 0, 0, 1);
         if (i == 0) begin
            checks++;
            if (tr_len !== 2 || tr_sn[1].PCSrc !== 2'b10 || tr_sn[1].PCWrite !== 1'b1) begin
               errors++;
               $display("FAIL j_latency: got len=%0d PCSrc=%b PCWrite=%b, want 2 10 1",
                        tr_len, tr_sn[1].PCSrc, tr_sn[1].PCWrite);
            end
         end
      end
      checks++;
      if (cnt4 !== 4'd0 || cnt16 !== 16'd16) begin
         errors++;
         $display("FAIL count_wrap: got cnt4=%0d cnt16=%0d, want 0 16", cnt4, cnt16);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_lw_wait();
      test_beq();
      test_shift();
      test_itype();
      test_trap();
      test_sw_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
